decoder_scan: RTL and testbench

Parametrised, registered successor to the 3-to-8 line decoder: decodes a SEL_W-bit index into 2^SEL_W one-hot outputs gated by a 74138-style enable triple. It adds a scan mode, in which an internal dwell timer steps the active output through indices 0..last_idx and wraps. It sits between control logic and multiplexed displays or LED matrices, driving digit and row selects directly.

---
 rtl/decoder_pkg.sv | 27 ++
 rtl/decoder_scan_if.sv | 27 ++
 rtl/decoder_dwell_timer.sv | 30 +++
 rtl/decoder_scan.sv | 92 +++++++++
 tb/tb_decoder_scan.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Shared constants, FSM state type and polarity-aware one-hot helper
// for the decoder_scan slice.
package decoder_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   localparam int unsigned MAX_OUT_W = 256;

   typedef enum logic {
      ST_DIRECT = 1'b0,
      ST_SCAN   = 1'b1
   } state_t;

   // Bits at or above width stay 0; callers truncate to their output width.
   function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned idx,
                                                  input int unsigned width,
                                                  input logic        active_low);
      logic [MAX_OUT_W-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < MAX_OUT_W; i++) begin
         if (i < width) v[8'(i)] = (i == idx) ? ~active_low : active_low;
      end
      return v;
   endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// Control/decode bus between the controller (master) and decoder_scan (slave).
interface decoder_scan_if #(
   parameter int unsigned SEL_W = 3
);
   localparam int unsigned OUT_W = 1 << SEL_W;

   logic             g1;
   logic             g2a_n;
   logic             g2b_n;
   logic             mode;
   logic [SEL_W-1:0] sel;
   logic [SEL_W-1:0] last_idx;
   logic [OUT_W-1:0] y;
   logic [SEL_W-1:0] idx;
   logic             tick;

   modport master (
      output g1, g2a_n, g2b_n, mode, sel, last_idx,
      input  y, idx, tick
   );

   modport slave (
      input  g1, g2a_n, g2b_n, mode, sel, last_idx,
      output y, idx, tick
   );

endinterface

// File: rtl/decoder_dwell_timer.sv
// Dwell counter for scan mode: counts run cycles and flags the last one of
// each DWELL-cycle period.
module decoder_dwell_timer #(
   parameter int unsigned DWELL = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clr,
   output logic done
);

   localparam int unsigned CNT_W = $clog2(DWELL + 1);

   logic [CNT_W-1:0] count;

   assign done = (count == CNT_W'(DWELL - 1));

   // Wraps only through the done compare, so no overflow handling needed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (run) begin
         count <= done ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/decoder_scan.sv
// Registered 74138-style decoder with enable triple and a timed scan mode
// that steps the active output through 0..last_idx.
module decoder_scan
   import decoder_pkg::*;
#(
   parameter int unsigned SEL_W      = 3,
   parameter int unsigned DWELL      = 50000,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   decoder_scan_if.slave  bus
);

   localparam int unsigned OUT_W = 1 << SEL_W;

   state_t           state;
   state_t           state_nxt;
   logic             en;
   logic             run;
   logic             clr;
   logic             done;
   logic             advance;
   logic [SEL_W-1:0] idx_nxt;
   logic [OUT_W-1:0] y_nxt;

   assign en = bus.g1 & ~bus.g2a_n & ~bus.g2b_n;

   decoder_dwell_timer #(
      .DWELL (DWELL)
   ) u_dwell_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (run),
      .clr   (clr),
      .done  (done)
   );

   // Reset leaves idx and dwell count at their scan start values, so the
   // reset state behaves as an already-entered scan.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_SCAN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      run       = 1'b0;
      clr       = 1'b0;
      advance   = 1'b0;
      idx_nxt   = bus.idx;
      y_nxt     = {OUT_W{ACTIVE_LOW}};
      if (en) begin
         if (bus.mode == MODE_DIRECT) begin
            state_nxt = ST_DIRECT;
            clr       = 1'b1;
            idx_nxt   = bus.sel;
         end else begin
            case (state)
               ST_DIRECT: begin
                  // First scan cycle: restart at index 0 with a full dwell.
                  state_nxt = ST_SCAN;
                  clr       = 1'b1;
                  idx_nxt   = '0;
               end
               default: begin
                  run = 1'b1;
                  if (done) begin
                     advance = 1'b1;
                     idx_nxt = (bus.idx >= bus.last_idx) ? '0 : bus.idx + SEL_W'(1);
                  end
               end
            endcase
         end
         y_nxt = OUT_W'(onehot(32'(idx_nxt), OUT_W, ACTIVE_LOW));
      end
   end

   // Output register: y shows the index that idx reports in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.y    <= {OUT_W{ACTIVE_LOW}};
         bus.idx  <= '0;
         bus.tick <= 1'b0;
      end else begin
         bus.y    <= y_nxt;
         bus.idx  <= idx_nxt;
         bus.tick <= advance;
      end
   end

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan (SEL_W=3, DWELL=4, ACTIVE_LOW=1): vector
// table for direct decode/gating, hand sequences for scan behaviour.
module tb_decoder_scan;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   decoder_scan_if #(.SEL_W(3)) bus ();

   decoder_scan #(
      .SEL_W      (3),
      .DWELL      (4),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       g1;
      logic       g2a_n;
      logic       g2b_n;
      logic       mode;
      logic [2:0] sel;
      logic [7:0] exp_y;
      logic [2:0] exp_idx;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic g1, input logic g2a_n, input logic g2b_n,
                               input logic [2:0] sel, input logic [7:0] ey, input logic [2:0] eidx);
      vec_t v;
      v.g1 = g1; v.g2a_n = g2a_n; v.g2b_n = g2b_n; v.mode = 1'b0;
      v.sel = sel; v.exp_y = ey; v.exp_idx = eidx;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input logic [7:0] ey,
                            input logic [2:0] eidx, input logic etick);
      check({name, ".y"},    32'(bus.y),    32'(ey));
      check({name, ".idx"},  32'(bus.idx),  32'(eidx));
      check({name, ".tick"}, 32'(bus.tick), 32'(etick));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic g1, input logic g2a_n, input logic g2b_n,
                        input logic mode, input logic [2:0] sel, input logic [2:0] last);
      bus.g1 = g1; bus.g2a_n = g2a_n; bus.g2b_n = g2b_n;
      bus.mode = mode; bus.sel = sel; bus.last_idx = last;
   endtask

   function automatic logic [7:0] exp_y(input logic [2:0] i);
      logic [7:0] one;
      one = 8'h01;
      return ~(one << i);
   endfunction

   initial begin
      checks   = 0;
      failures = 0;

      // Reset with random inputs
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               3'($urandom), 3'($urandom));
         step();
      end
      check_out("reset", 8'hFF, 3'd0, 1'b0);
      rst_n = 1'b1;

      // Direct decode sweep, then enable gating around sel=5
      add(1, 0, 0, 3'd0, 8'hFE, 3'd0);
      add(1, 0, 0, 3'd1, 8'hFD, 3'd1);
      add(1, 0, 0, 3'd2, 8'hFB, 3'd2);
      add(1, 0, 0, 3'd3, 8'hF7, 3'd3);
      add(1, 0, 0, 3'd4, 8'hEF, 3'd4);
      add(1, 0, 0, 3'd5, 8'hDF, 3'd5);
      add(1, 0, 0, 3'd6, 8'hBF, 3'd6);
      add(1, 0, 0, 3'd7, 8'h7F, 3'd7);
      add(0, 0, 0, 3'd5, 8'hFF, 3'd7);
      add(1, 0, 0, 3'd5, 8'hDF, 3'd5);
      add(1, 1, 0, 3'd2, 8'hFF, 3'd5);
      add(1, 0, 0, 3'd5, 8'hDF, 3'd5);
      add(1, 0, 1, 3'd1, 8'hFF, 3'd5);
      add(1, 0, 0, 3'd5, 8'hDF, 3'd5);

      foreach (vecs[k]) begin
         drive(vecs[k].g1, vecs[k].g2a_n, vecs[k].g2b_n, vecs[k].mode, vecs[k].sel, 3'd7);
         step();
         check_out($sformatf("vec%0d", k), vecs[k].exp_y, vecs[k].exp_idx, 1'b0);
      end

      // Scan entry from direct: index 0 with a full dwell, then wrap at 7
      drive(1, 0, 0, 1, 3'd5, 3'd7);
      step();
      check_out("scan_entry", 8'hFE, 3'd0, 1'b0);
      for (int c = 1; c <= 33; c++) begin
         logic [2:0] ei;
         ei = 3'((c / 4) % 8);
         step();
         check_out($sformatf("scan_c%0d", c), exp_y(ei), ei, (c % 4) == 0);
      end

      // Disabled cycles freeze the dwell (idx 0, one count consumed)
      drive(0, 0, 0, 1, 3'd5, 3'd7);
      for (int d = 1; d <= 3; d++) begin
         step();
         check_out($sformatf("stretch_off%0d", d), 8'hFF, 3'd0, 1'b0);
      end
      drive(1, 0, 0, 1, 3'd5, 3'd7);
      step(); check_out("stretch_on1", 8'hFE, 3'd0, 1'b0);
      step(); check_out("stretch_on2", 8'hFE, 3'd0, 1'b0);
      step(); check_out("stretch_on3", 8'hFD, 3'd1, 1'b1);

      // Advance to idx 5, then shrink range to 2
      for (int s = 1; s <= 16; s++) begin
         logic [2:0] ei;
         ei = 3'(1 + s / 4);
         step();
         check_out($sformatf("pre_shrink%0d", s), exp_y(ei), ei, (s % 4) == 0);
      end
      drive(1, 0, 0, 1, 3'd5, 3'd2);
      for (int s = 1; s <= 16; s++) begin
         logic [2:0] ei;
         if (s < 4)       ei = 3'd5;
         else if (s < 8)  ei = 3'd0;
         else if (s < 12) ei = 3'd1;
         else if (s < 16) ei = 3'd2;
         else             ei = 3'd0;
         step();
         check_out($sformatf("shrink%0d", s), exp_y(ei), ei, (s % 4) == 0);
      end

      // Reset mid-scan at idx 3
      drive(1, 0, 0, 1, 3'd5, 3'd7);
      for (int s = 1; s <= 13; s++) step();
      check_out("pre_reset", 8'hF7, 3'd3, 1'b0);
      rst_n = 1'b0;
      step();
      check_out("mid_reset", 8'hFF, 3'd0, 1'b0);
      rst_n = 1'b1;
      for (int s = 1; s <= 4; s++) begin
         step();
         if (s < 4) check_out($sformatf("post_reset%0d", s), 8'hFE, 3'd0, 1'b0);
         else       check_out("post_reset4", 8'hFD, 3'd1, 1'b1);
      end

      // Scan to direct: sel applies on the next edge
      drive(1, 0, 0, 0, 3'd6, 3'd7);
      step();
      check_out("to_direct", 8'hBF, 3'd6, 1'b0);

      // last_idx = 0: idx pinned at 0, tick every 4 cycles
      drive(1, 0, 0, 1, 3'd6, 3'd0);
      step();
      check_out("last0_entry", 8'hFE, 3'd0, 1'b0);
      for (int s = 1; s <= 8; s++) begin
         step();
         check_out($sformatf("last0_%0d", s), 8'hFE, 3'd0, (s % 4) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
